// File: rtl/rib_arb_pkg.sv
// rib_arb_pkg -- shared definitions for the RIB bus arbiter.
//   NUM_MST      : number of RIB masters
//   ID_W         : width of a master index
//   arb_state_e  : arbiter FSM encodings
//   HoldEnable / HoldDisable : levels driven on the core stall request
//   oh2id()      : one-hot grant to binary index
package rib_arb_pkg;

  localparam int NUM_MST = 4;
  localparam int ID_W    = $clog2(NUM_MST);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;

  function automatic logic [ID_W-1:0] oh2id(input logic [NUM_MST-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_MST; i++)
      if (oh[i]) id = id | ID_W'(i);
    return id;
  endfunction

endpackage

// File: rtl/rib_rr_pick.sv
// rib_rr_pick -- combinational rotate-priority picker.
//   req : request vector
//   ptr : highest-priority index; search order ptr, ptr+1, ... (mod NUM_MST)
//   gnt : one-hot first requester in search order, zero when req is zero
module rib_rr_pick
  import rib_arb_pkg::*;
(
  input  logic [NUM_MST-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_MST-1:0] gnt
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      idx = ptr + ID_W'(i);   // wraps naturally modulo NUM_MST
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_arb.sv
// rib_arb -- 4-master round-robin arbiter for the RIB bus.
//   clk, rst     : clock, asynchronous active-high reset
//   req_i        : per-master access requests
//   grant_o      : registered one-hot grant (zero when idle)
//   grant_id_o   : binary owner index (0 when idle)
//   grant_vld_o  : grant_o is non-zero
//   hold_flag_o  : combinational stall request, any requester not granted
//   timeout_o    : one-cycle pulse when the owner is forcibly revoked
// Optional feature: define RIB_ARB_TIMEOUT_EN to enable hold-time revocation
// after MAX_HOLD owned cycles; without it timeout_o is tied low.
module rib_arb
  import rib_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_MST-1:0]  req_i,
  output logic [NUM_MST-1:0]  grant_o,
  output logic [ID_W-1:0]     grant_id_o,
  output logic                grant_vld_o,
  output logic                hold_flag_o,
  output logic                timeout_o
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    id_q;
  logic               timeout_d;

  logic [NUM_MST-1:0] others;
  logic               owner_req;
  logic [ID_W-1:0]    ptr_rel;
  logic [NUM_MST-1:0] pick_req, pick_gnt;
  logic [ID_W-1:0]    pick_ptr;
  logic               revoke;

  assign owner_req = |(req_i & grant_q);
  assign others    = req_i & ~grant_q;
  assign ptr_rel   = id_q + ID_W'(1);

  // One picker serves both cases: from IDLE it searches all requests from
  // ptr; from BUSY it searches the non-owners starting just past the owner.
  assign pick_req = (state_q == ST_BUSY) ? others  : req_i;
  assign pick_ptr = (state_q == ST_BUSY) ? ptr_rel : ptr_q;

  rib_rr_pick u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LIM  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  // >= rather than ==: once saturated with nobody waiting, a late arrival
  // must still be able to force the handover.
  assign revoke = (state_q == ST_BUSY) && owner_req && (|others) &&
                  (cnt_q >= HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt_q <= '0;
    else if (grant_d != grant_q)     cnt_q <= '0;
    else if (state_q == ST_BUSY && cnt_q != HOLD_LIM)
                                     cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_d;
  end

  assign timeout_o = timeout_q;
`else
  assign revoke    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_BUSY;
          grant_d = pick_gnt;
        end
      end
      ST_BUSY: begin
        if (!owner_req || revoke) begin
          ptr_d     = ptr_rel;
          timeout_d = revoke;
          grant_d   = pick_gnt;
          if (!(|others)) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= oh2id(grant_d);
    end
  end

  assign grant_o     = grant_q;
  assign grant_id_o  = id_q;
  assign grant_vld_o = |grant_q;
  assign hold_flag_o = (|(req_i & ~grant_q)) ? HoldEnable : HoldDisable;

endmodule

// File: tb/tb_rib_arb.sv
// tb_rib_arb -- directed self-checking bench for rib_arb (MAX_HOLD=4).
module tb_rib_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] grant_o;
  logic [1:0] grant_id_o;
  logic       grant_vld_o;
  logic       hold_flag_o;
  logic       timeout_o;

  int n_chk;
  int n_err;

  rib_arb #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .grant_o     (grant_o),
    .grant_id_o  (grant_id_o),
    .grant_vld_o (grant_vld_o),
    .hold_flag_o (hold_flag_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // grant plus the outputs that must track it
  task automatic chk_gnt(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".gnt"}, 32'(grant_o), 32'(g));
    chk({tag, ".id"},  32'(grant_id_o), 32'(id));
    chk({tag, ".vld"}, 32'(grant_vld_o), 32'(g != 4'b0000));
    chk({tag, ".to"},  32'(timeout_o), 32'(0));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    req_i = 4'b0000;
    tick();
    tick();
    chk_gnt("rst", 4'b0000, 2'd0);

    // first grant, 1-cycle latency
    rst = 1'b0;
    tick();
    req_i = 4'b0001;
    #1;
    chk("lat.hold", 32'(hold_flag_o), 32'(1));
    chk("lat.gnt",  32'(grant_o), 32'(0));
    tick();
    chk_gnt("g0", 4'b0001, 2'd0);
    chk("g0.hold", 32'(hold_flag_o), 32'(0));

    // rotation 0->1->2->3->0
    req_i = 4'b1111;
    #1;
    chk("all.hold", 32'(hold_flag_o), 32'(1));
    tick();
    chk_gnt("keep0", 4'b0001, 2'd0);
    req_i = 4'b1110; tick(); chk_gnt("rot1", 4'b0010, 2'd1);
    req_i = 4'b1101; tick(); chk_gnt("rot2", 4'b0100, 2'd2);
    req_i = 4'b1011; tick(); chk_gnt("rot3", 4'b1000, 2'd3);
    req_i = 4'b0111; tick(); chk_gnt("wrap0", 4'b0001, 2'd0);

    // owner 2 releases to idle, ptr=3, then 1001 -> master 3
    req_i = 4'b0110; tick(); chk_gnt("to1", 4'b0010, 2'd1);
    req_i = 4'b0100; tick(); chk_gnt("to2", 4'b0100, 2'd2);
    req_i = 4'b0000; tick(); chk_gnt("idle", 4'b0000, 2'd0);
    chk("idle.hold", 32'(hold_flag_o), 32'(0));
    tick();
    req_i = 4'b1001; tick(); chk_gnt("ptr3", 4'b1000, 2'd3);

    // reset mid-ownership drops the grant before the next edge
    req_i = 4'b1000;
    tick();
    chk_gnt("own3", 4'b1000, 2'd3);
    #2 rst = 1'b1;
    #1;
    chk_gnt("async", 4'b0000, 2'd0);
    tick();
    rst   = 1'b0;
    req_i = 4'b1111;
    tick();
    chk_gnt("ptr0", 4'b0001, 2'd0);

    // a request withdrawn before the edge is never granted
    req_i = 4'b0000; tick(); chk_gnt("idle2", 4'b0000, 2'd0);
    req_i = 4'b0100;
    #3 req_i = 4'b0000;
    tick();
    chk_gnt("wdraw", 4'b0000, 2'd0);

    // master 1 holds while master 0 waits
    req_i = 4'b0010; tick(); chk_gnt("h1", 4'b0010, 2'd1);
    req_i = 4'b0011;
    tick(); chk_gnt("h1.c1", 4'b0010, 2'd1);
    tick(); chk_gnt("h1.c2", 4'b0010, 2'd1);
    tick(); chk_gnt("h1.c3", 4'b0010, 2'd1);
    tick();
`ifdef RIB_ARB_TIMEOUT_EN
    chk("rev.gnt", 32'(grant_o), 32'(4'b0001));
    chk("rev.id",  32'(grant_id_o), 32'(0));
    chk("rev.to",  32'(timeout_o), 32'(1));
    tick();
    chk_gnt("rev.pulse", 4'b0001, 2'd0);
    // sole requester keeps the bus with the counter saturated
    req_i = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_gnt("sat", 4'b0001, 2'd0);
    end
    // late arrival against a saturated counter revokes at once
    req_i = 4'b0011;
    tick();
    chk("late.gnt", 32'(grant_o), 32'(4'b0010));
    chk("late.to",  32'(timeout_o), 32'(1));
    tick();
    chk_gnt("late.pulse", 4'b0010, 2'd1);
`else
    for (int i = 0; i < 8; i++) begin
      chk_gnt("nohold", 4'b0010, 2'd1);
      tick();
    end
    chk("nohold.hold", 32'(hold_flag_o), 32'(1));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
